// File: rtl/mem_fill_engine_if.sv
// Start/config handshake and RAM write port of the memory fill engine.
// master drives requests, slave is the engine itself.
interface mem_fill_engine_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              en;
    logic              rdy;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] fill_val;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wrdata;
    logic              wren;
    logic              done;

    modport master (
        output en, mode, base_addr, count, fill_val,
        input  rdy, addr, wrdata, wren, done
    );

    modport slave (
        input  en, mode, base_addr, count, fill_val,
        output rdy, addr, wrdata, wren, done
    );
endinterface

// File: rtl/mem_fill_engine.sv
// Streams one RAM write per cycle over a wrapping base/count window,
// with identity, constant, reverse and ramp data patterns.
module mem_fill_engine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic clk,
    input  logic rst,
    mem_fill_engine_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] ZERO  = '0;

    state_t            state;
    state_t            state_nx;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   i_q;
    logic [DATA_W-1:0] fill_q;

    logic [ADDR_W:0]   cnt_clamp;
    logic              accept;
    logic              last;
    logic              rdy;
    logic              wren;
    logic              done;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_rev;
    logic [DATA_W-1:0] wrdata;

    // count is one bit wider than the address, so only the MSB can exceed depth
    assign cnt_clamp = bus.count[ADDR_W] ? DEPTH : bus.count;
    assign accept    = (state == IDLE) && bus.en;
    assign last      = ((i_q + ONE) == cnt_q);
    assign addr      = base_q + i_q[ADDR_W-1:0];
    assign addr_rev  = ~addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= '0;
            base_q <= '0;
            cnt_q  <= '0;
            i_q    <= '0;
            fill_q <= '0;
        end else if (accept) begin
            mode_q <= bus.mode;
            base_q <= bus.base_addr;
            cnt_q  <= cnt_clamp;
            i_q    <= '0;
            fill_q <= bus.fill_val;
        end else if (state == FILL) begin
            i_q <= i_q + ONE;
        end
    end

    always_comb begin
        state_nx = state;
        rdy      = 1'b0;
        wren     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                rdy = 1'b1;
                if (bus.en) begin
                    state_nx = (cnt_clamp == ZERO) ? DONE : FILL;
                end
            end
            FILL: begin
                wren = 1'b1;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        wrdata = '0;
        unique case (mode_q)
            2'd0: wrdata = DATA_W'(addr);
            2'd1: wrdata = fill_q;
            2'd2: wrdata = DATA_W'(addr_rev);
            2'd3: wrdata = fill_q + DATA_W'(i_q);
            default: wrdata = '0;
        endcase
    end

    assign bus.rdy    = rdy;
    assign bus.wren   = wren;
    assign bus.done   = done;
    assign bus.addr   = addr;
    assign bus.wrdata = wrdata;
endmodule

// File: tb/tb_mem_fill_engine.sv
// Directed bench for mem_fill_engine with a RAM model tagging each pass.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mem_fill_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_fill_engine_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    mem_fill_engine #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem [256];
    int         wr_tag [256];
    int         tag    = 0;
    int         n_wr   = 0;
    int         n_done = 0;
    int         total  = 0;
    int         bad    = 0;

    // RAM model: each write records the pass tag current at that time
    always @(posedge clk) begin
        if (bus.wren === 1'b1) begin
            mem[bus.addr]    <= bus.wrdata;
            wr_tag[bus.addr] <= tag;
            n_wr             <= n_wr + 1;
        end
        if (bus.done === 1'b1) begin
            n_done <= n_done + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pass(input logic [1:0] m, input logic [7:0] b,
                            input logic [8:0] c, input logic [7:0] f,
                            output int busy, output int done_at);
        bus.mode      = m;
        bus.base_addr = b;
        bus.count     = c;
        bus.fill_val  = f;
        bus.en        = 1'b1;
        tick();
        bus.en  = 1'b0;
        busy    = 0;
        done_at = -1;
        while (bus.rdy !== 1'b1 && busy < 2000) begin
            if (bus.done === 1'b1 && done_at < 0) done_at = busy;
            busy++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (bus.rdy !== 1'b1) begin
            bad++; $display("FAIL reset_rdy: got %b want 1", bus.rdy);
        end
        total++;
        if (bus.wren !== 1'b0) begin
            bad++; $display("FAIL reset_wren: got %b want 0", bus.wren);
        end
        total++;
        if (bus.done !== 1'b0) begin
            bad++; $display("FAIL reset_done: got %b want 0", bus.done);
        end
        total++;
        if (bus.addr !== 8'h00) begin
            bad++; $display("FAIL reset_addr: got %h want 00", bus.addr);
        end
        total++;
        if (bus.wrdata !== 8'h00) begin
            bad++; $display("FAIL reset_wrdata: got %h want 00", bus.wrdata);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_identity_full();
        int w0, d0, busy, dat, errs, low;
        tag = 1;
        w0  = n_wr;
        d0  = n_done;
        run_pass(2'd0, 8'h00, 9'd256, 8'h00, busy, dat);
        total++;
        if (busy !== 257) begin
            bad++; $display("FAIL full_busy: got %0d want 257", busy);
        end
        total++;
        if (n_wr - w0 !== 256) begin
            bad++; $display("FAIL full_writes: got %0d want 256", n_wr - w0);
        end
        total++;
        if (n_done - d0 !== 1) begin
            bad++; $display("FAIL full_dones: got %0d want 1", n_done - d0);
        end
        total++;
        if (dat !== 256) begin
            bad++; $display("FAIL full_done_at: got %0d want 256", dat);
        end
        errs = 0;
        for (int a = 0; a < 256; a++) begin
            if (wr_tag[a] != 1 || mem[a] !== 8'(a)) errs++;
        end
        total++;
        if (errs !== 0) begin
            bad++; $display("FAIL full_data: got %0d bad locations want 0", errs);
        end
        w0  = n_wr;
        low = 0;
        repeat (256) begin
            if (bus.rdy !== 1'b1) low++;
            tick();
        end
        total++;
        if (low !== 0) begin
            bad++; $display("FAIL hold_rdy: got %0d low cycles want 0", low);
        end
        total++;
        if (n_wr - w0 !== 0) begin
            bad++; $display("FAIL hold_writes: got %0d want 0", n_wr - w0);
        end
    endtask

    task automatic test_const_wrap();
        int w0, busy, dat, errs;
        logic inw;
        tag = 2;
        w0  = n_wr;
        run_pass(2'd1, 8'hF0, 9'd32, 8'hA5, busy, dat);
        total++;
        if (busy !== 33) begin
            bad++; $display("FAIL wrap_busy: got %0d want 33", busy);
        end
        total++;
        if (n_wr - w0 !== 32) begin
            bad++; $display("FAIL wrap_writes: got %0d want 32", n_wr - w0);
        end
        errs = 0;
        for (int a = 0; a < 256; a++) begin
            inw = (a >= 240) || (a < 16);
            if (inw) begin
                if (wr_tag[a] != 2 || mem[a] !== 8'hA5) errs++;
            end else if (wr_tag[a] == 2) begin
                errs++;
            end
        end
        total++;
        if (errs !== 0) begin
            bad++; $display("FAIL wrap_data: got %0d bad locations want 0", errs);
        end
    endtask

    task automatic test_ramp_reverse();
        logic [7:0] r_exp [4];
        logic [7:0] v_exp [3];
        int busy, dat;
        r_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        v_exp = '{8'hFF, 8'hFE, 8'hFD};
        tag = 3;
        run_pass(2'd3, 8'd10, 9'd4, 8'hFE, busy, dat);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (wr_tag[10+i] != 3 || mem[10+i] !== r_exp[i]) begin
                bad++;
                $display("FAIL ramp_mem%0d: got %h want %h", 10 + i, mem[10+i], r_exp[i]);
            end
        end
        tag = 4;
        run_pass(2'd2, 8'd0, 9'd3, 8'h00, busy, dat);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (wr_tag[i] != 4 || mem[i] !== v_exp[i]) begin
                bad++;
                $display("FAIL rev_mem%0d: got %h want %h", i, mem[i], v_exp[i]);
            end
        end
    endtask

    task automatic test_count_edges();
        int w0, d0, busy, dat, errs;
        tag = 5;
        w0  = n_wr;
        d0  = n_done;
        run_pass(2'd0, 8'h40, 9'd0, 8'h00, busy, dat);
        total++;
        if (busy !== 1) begin
            bad++; $display("FAIL zero_busy: got %0d want 1", busy);
        end
        total++;
        if (dat !== 0) begin
            bad++; $display("FAIL zero_done_at: got %0d want 0", dat);
        end
        total++;
        if (n_wr - w0 !== 0) begin
            bad++; $display("FAIL zero_writes: got %0d want 0", n_wr - w0);
        end
        total++;
        if (n_done - d0 !== 1) begin
            bad++; $display("FAIL zero_dones: got %0d want 1", n_done - d0);
        end
        tag = 6;
        w0  = n_wr;
        run_pass(2'd1, 8'h10, 9'd300, 8'h3C, busy, dat);
        total++;
        if (busy !== 257) begin
            bad++; $display("FAIL clamp_busy: got %0d want 257", busy);
        end
        total++;
        if (n_wr - w0 !== 256) begin
            bad++; $display("FAIL clamp_writes: got %0d want 256", n_wr - w0);
        end
        errs = 0;
        for (int a = 0; a < 256; a++) begin
            if (wr_tag[a] != 6 || mem[a] !== 8'h3C) errs++;
        end
        total++;
        if (errs !== 0) begin
            bad++; $display("FAIL clamp_data: got %0d bad locations want 0", errs);
        end
    endtask

    task automatic test_back_to_back();
        int busy1, busy2, gap, errs;
        tag           = 7;
        bus.mode      = 2'd1;
        bus.base_addr = 8'h20;
        bus.count     = 9'd4;
        bus.fill_val  = 8'h11;
        bus.en        = 1'b1;
        tick();
        bus.mode      = 2'd3;
        bus.base_addr = 8'h80;
        bus.count     = 9'd2;
        bus.fill_val  = 8'h40;
        busy1 = 0;
        while (bus.rdy !== 1'b1 && busy1 < 2000) begin
            busy1++;
            tick();
        end
        gap = 0;
        while (bus.rdy === 1'b1 && gap < 10) begin
            gap++;
            tick();
        end
        total++;
        if (busy1 !== 5) begin
            bad++; $display("FAIL b2b_busy1: got %0d want 5", busy1);
        end
        total++;
        if (gap !== 1) begin
            bad++; $display("FAIL b2b_gap: got %0d want 1", gap);
        end
        total++;
        if (bus.wren !== 1'b1 || bus.addr !== 8'h80 || bus.wrdata !== 8'h40) begin
            bad++;
            $display("FAIL b2b_first: got wren=%b addr=%h data=%h want 1 80 40",
                     bus.wren, bus.addr, bus.wrdata);
        end
        bus.en = 1'b0;
        busy2  = 0;
        while (bus.rdy !== 1'b1 && busy2 < 2000) begin
            busy2++;
            tick();
        end
        total++;
        if (busy2 !== 3) begin
            bad++; $display("FAIL b2b_busy2: got %0d want 3", busy2);
        end
        errs = 0;
        for (int a = 32; a < 36; a++) begin
            if (wr_tag[a] != 7 || mem[a] !== 8'h11) errs++;
        end
        total++;
        if (errs !== 0) begin
            bad++; $display("FAIL b2b_pass1: got %0d bad locations want 0", errs);
        end
        total++;
        if (mem[8'h80] !== 8'h40 || mem[8'h81] !== 8'h41) begin
            bad++;
            $display("FAIL b2b_pass2: got %h %h want 40 41", mem[8'h80], mem[8'h81]);
        end
    endtask

    task automatic test_reset_mid_fill();
        int w0, d0, busy, dat, errs;
        tag           = 8;
        w0            = n_wr;
        d0            = n_done;
        bus.mode      = 2'd0;
        bus.base_addr = 8'h00;
        bus.count     = 9'd256;
        bus.fill_val  = 8'h00;
        bus.en        = 1'b1;
        tick();
        bus.en = 1'b0;
        repeat (48) tick();
        total++;
        if (bus.wren !== 1'b1 || bus.addr !== 8'd48) begin
            bad++; $display("FAIL mid_pre: got wren=%b addr=%0d want 1 48", bus.wren, bus.addr);
        end
        rst = 1'b1;
        tick();
        total++;
        if (bus.rdy !== 1'b1 || bus.wren !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst: got rdy=%b wren=%b done=%b want 1 0 0",
                     bus.rdy, bus.wren, bus.done);
        end
        rst = 1'b0;
        repeat (5) tick();
        total++;
        if (n_done - d0 !== 0) begin
            bad++; $display("FAIL mid_dones: got %0d want 0", n_done - d0);
        end
        total++;
        if (n_wr - w0 !== 49) begin
            bad++; $display("FAIL mid_writes: got %0d want 49", n_wr - w0);
        end
        errs = 0;
        for (int a = 0; a < 256; a++) begin
            if (a < 49) begin
                if (wr_tag[a] != 8 || mem[a] !== 8'(a)) errs++;
            end else if (wr_tag[a] == 8) begin
                errs++;
            end
        end
        total++;
        if (errs !== 0) begin
            bad++; $display("FAIL mid_data: got %0d bad locations want 0", errs);
        end
        tag = 9;
        run_pass(2'd0, 8'h00, 9'd256, 8'h00, busy, dat);
        total++;
        if (busy !== 257) begin
            bad++; $display("FAIL after_busy: got %0d want 257", busy);
        end
        errs = 0;
        for (int a = 0; a < 256; a++) begin
            if (wr_tag[a] != 9 || mem[a] !== 8'(a)) errs++;
        end
        total++;
        if (errs !== 0) begin
            bad++; $display("FAIL after_data: got %0d bad locations want 0", errs);
        end
    endtask

    initial begin
        bus.en        = 1'b0;
        bus.mode      = 2'd0;
        bus.base_addr = 8'h00;
        bus.count     = 9'd0;
        bus.fill_val  = 8'h00;
        test_reset();
        test_identity_full();
        test_const_wrap();
        test_ramp_reverse();
        test_count_edges();
        test_back_to_back();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
